// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, stall, flush
// and a saturating bubble counter. Control bits read as zero whenever the
// stage presents no valid op.
// Optional feature: define SKID_BUF_EN to add a one-entry skid buffer, which
// removes the combinational out_ready -> in_ready path.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 106,
  parameter int unsigned CTRL_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              r_vld;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_vld_d;
  logic [DATA_W-1:0] w_data_d;
  logic [CTRL_W-1:0] w_ctrl_d;
  logic              w_in_fire;
  logic              w_out_fire;

  // Stall masks the presented op without touching the registers.
  assign out_valid  = r_vld & ~stall;
  assign out_ctrl   = out_valid ? r_ctrl : '0;
  assign out_data   = r_data;
  assign bubble_cnt = r_cnt;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

`ifdef SKID_BUF_EN
  logic              r_skid_vld;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic              w_skid_vld_d;
  logic [DATA_W-1:0] w_skid_data_d;
  logic [CTRL_W-1:0] w_skid_ctrl_d;

  assign in_ready = ~reset & ~r_skid_vld & ~stall & ~flush;

  // Next state: main slot refills from skid first so ordering is preserved.
  always_comb begin
    w_vld_d       = r_vld;
    w_data_d      = r_data;
    w_ctrl_d      = r_ctrl;
    w_skid_vld_d  = r_skid_vld;
    w_skid_data_d = r_skid_data;
    w_skid_ctrl_d = r_skid_ctrl;
    if (flush) begin
      w_vld_d      = 1'b0;
      w_ctrl_d     = '0;
      w_skid_vld_d = 1'b0;
    end else if (!stall) begin
      if (w_out_fire || !r_vld) begin
        if (r_skid_vld) begin
          w_vld_d       = 1'b1;
          w_data_d      = r_skid_data;
          w_ctrl_d      = r_skid_ctrl;
          w_skid_vld_d  = w_in_fire;
          w_skid_data_d = w_in_fire ? in_data : r_skid_data;
          w_skid_ctrl_d = w_in_fire ? in_ctrl : r_skid_ctrl;
        end else if (w_in_fire) begin
          w_vld_d  = 1'b1;
          w_data_d = in_data;
          w_ctrl_d = in_ctrl;
        end else begin
          w_vld_d  = 1'b0;
          w_ctrl_d = '0;
        end
      end else if (w_in_fire) begin
        w_skid_vld_d  = 1'b1;
        w_skid_data_d = in_data;
        w_skid_ctrl_d = in_ctrl;
      end
    end
  end

  // Skid entry registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_skid_vld  <= 1'b0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else begin
      r_skid_vld  <= w_skid_vld_d;
      r_skid_data <= w_skid_data_d;
      r_skid_ctrl <= w_skid_ctrl_d;
    end
  end
`else
  assign in_ready = ~reset & ~stall & ~flush & (~r_vld | out_ready);

  // Next state: load on accept, drain to a bubble on output-only transfer.
  always_comb begin
    w_vld_d  = r_vld;
    w_data_d = r_data;
    w_ctrl_d = r_ctrl;
    if (flush) begin
      w_vld_d  = 1'b0;
      w_ctrl_d = '0;
    end else if (!stall) begin
      if (w_in_fire) begin
        w_vld_d  = 1'b1;
        w_data_d = in_data;
        w_ctrl_d = in_ctrl;
      end else if (w_out_fire) begin
        w_vld_d  = 1'b0;
        w_ctrl_d = '0;
      end
    end
  end
`endif

  // Main stage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld  <= 1'b0;
      r_data <= '0;
      r_ctrl <= '0;
    end else begin
      r_vld  <= w_vld_d;
      r_data <= w_data_d;
      r_ctrl <= w_ctrl_d;
    end
  end

  // Bubble counter: counts cycles whose updated valid is 0, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!w_vld_d && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg (CNT_W=4 so saturation is reachable).
module tb_pipe_stage_reg;
  localparam int unsigned DataW = 106;
  localparam int unsigned CtrlW = 5;
  localparam int unsigned CntW  = 4;
`ifdef SKID_BUF_EN
  localparam bit Skid = 1'b1;
`else
  localparam bit Skid = 1'b0;
`endif

  typedef struct packed {
    logic [DataW-1:0] d;
    logic [CtrlW-1:0] c;
  } op_t;

  logic             clk = 1'b0;
  logic             reset, stall, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DataW-1:0] in_data, out_data;
  logic [CtrlW-1:0] in_ctrl, out_ctrl;
  logic [CntW-1:0]  bubble_cnt;

  int n_cmp = 0;
  int n_err = 0;

  op_t              sb[$];
  op_t              head;
  logic [CntW-1:0]  m_cnt = '0;
  logic             exp_vld, exp_rdy, ofire, ifire;
  logic [CtrlW-1:0] exp_ctrl;

  pipe_stage_reg #(.DATA_W(DataW), .CTRL_W(CtrlW), .CNT_W(CntW)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model, evaluated mid-cycle with the inputs for the next edge.
  always @(negedge clk) begin
    exp_vld  = (sb.size() > 0) && !stall;
    exp_ctrl = exp_vld ? sb[0].c : '0;
    exp_rdy  = !reset && !stall && !flush &&
               (Skid ? (sb.size() < 2) : (sb.size() == 0 || out_ready));
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, exp_vld);
    chk("out_ctrl", out_ctrl, exp_ctrl);
    chk("bubble_cnt", bubble_cnt, m_cnt);
    if (reset) begin
      sb.delete();
      m_cnt = '0;
    end else begin
      if (flush) begin
        sb.delete();
      end else begin
        ofire = exp_vld && out_ready;
        ifire = in_valid && exp_rdy;
        if (ofire) begin
          head = sb.pop_front();
          chk("out_data", out_data, head.d);
        end
        if (ifire) sb.push_back({in_data, in_ctrl});
      end
      if (sb.size() == 0 && m_cnt != '1) m_cnt = m_cnt + 1'b1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DataW-1:0] d, input logic [CtrlW-1:0] c);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, 'h99, 5'h01);
    cyc(2);
    chk("rst_data", out_data, '0);
    reset = 1'b0;
    drive(1'b0, '0, '0);
    cyc(2);

    // Back-to-back stream
    drive(1'b1, 'h11, 5'h03); cyc(1);
    drive(1'b1, 'h22, 5'h05); cyc(1);
    drive(1'b1, 'h33, 5'h09); cyc(1);
    drive(1'b0, '0, '0);      cyc(2);

    // Stall holds A, then A once and B follows
    drive(1'b1, 'hA1, 5'h11); cyc(1);
    stall = 1'b1;
    drive(1'b1, 'hB1, 5'h12); cyc(3);
    stall = 1'b0;             cyc(1);
    drive(1'b0, '0, '0);      cyc(2);

    // Flush with A in stage and B waiting
    out_ready = 1'b0;
    drive(1'b1, 'hA2, 5'b10111); cyc(1);
    flush = 1'b1;
    drive(1'b1, 'hB2, 5'h1e);    cyc(1);
    flush = 1'b0;
    drive(1'b0, '0, '0);         cyc(1);
    out_ready = 1'b1;            cyc(2);

    // Downstream back-pressure
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, DataW'(32'h500 + i), CtrlW'(i + 1));
      cyc(1);
    end
    drive(1'b0, '0, '0);
    out_ready = 1'b1; cyc(3);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
            CtrlW'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      cyc(1);
    end
    stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, '0, '0);

    // Bubble counter saturation
    reset = 1'b1; cyc(1);
    reset = 1'b0; cyc(20);
    chk("cnt_sat", bubble_cnt, 4'hF);
    cyc(3);
    chk("cnt_hold", bubble_cnt, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
